multdiv_issue_ctrl: RTL and testbench

Processor-side initiator for the iterative `multdiv` unit. It sits in the execute stage:
- captures a multiply/divide instruction and its operands;
- issues a single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse with stable operands;
- stalls the pipeline until `data_resultRDY`;
- presents one writeback beat, redirecting to the status register when the unit reports an exception.

---
 rtl/multdiv_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: execute-stage initiator for the iterative multdiv unit.
// Captures a mult/div instruction, fires a single start pulse, stalls the
// pipeline until the unit reports ready, then presents one writeback beat
// (redirected to the status register when the unit raises an exception).
// Optional feature: define MD_TIMEOUT_EN to abort BUSY after TIMEOUT cycles.
module multdiv_issue_ctrl #(
    parameter logic [4:0]  RSTATUS_REG  = 5'd30,
    parameter logic [31:0] RSTATUS_MULT = 32'd4,
    parameter logic [31:0] RSTATUS_DIV  = 32'd5
`ifdef MD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT      = 64
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        exc_q, exc_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        accept;

`ifdef MD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // A new instruction is taken only from IDLE and never while it is being squashed.
    assign accept = (state_q == IDLE) && issue_valid && !flush;

    // Next-state logic: operand/op capture, start pulse generation, result capture.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        exc_d       = exc_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
`ifdef MD_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d       = issue_opA;
                    opb_d       = issue_opB;
                    rd_d        = issue_rd;
                    is_div_d    = issue_is_div;
                    // Registered so the pulse lines up with the START cycle.
                    ctrl_mult_d = !issue_is_div;
                    ctrl_div_d  = issue_is_div;
                    state_d     = START;
                end
            end
            START: begin
                // Ready is deliberately ignored here: it may be left over from
                // the previous operation.
`ifdef MD_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = flush ? IDLE : BUSY;
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (data_resultRDY) begin
                    result_d = data_result;
                    exc_d    = data_exception;
                    state_d  = DONE;
                end
`ifdef MD_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    exc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            is_div_q    <= 1'b0;
            exc_q       <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
`ifdef MD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            is_div_q    <= is_div_d;
            exc_q       <= exc_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
`ifdef MD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign data_operandA = opa_q;
    assign data_operandB = opb_q;
    assign ctrl_MULT     = ctrl_mult_q;
    assign ctrl_DIV      = ctrl_div_q;

    // Stall and writeback payload; payload is zero outside DONE.
    always_comb begin
        stall        = accept || (state_q == START) || (state_q == BUSY);
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        wb_exception = 1'b0;
        if (state_q == DONE) begin
            wb_valid     = !flush;
            wb_exception = exc_q;
            if (exc_q) begin
                wb_rd   = RSTATUS_REG;
                wb_data = is_div_q ? RSTATUS_DIV : RSTATUS_MULT;
            end else begin
                wb_rd   = rd_q;
                wb_data = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: transaction-level reference model plus a
// simple multdiv responder, directed scenarios and randomized operations.
module tb_multdiv_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    int checks   = 0;
    int failures = 0;

    // Observations gathered by run_op
    int          ob_nmult, ob_ndiv, ob_pulse_c, ob_nwb, ob_wbc;
    logic [31:0] ob_opa, ob_opb, ob_wbdata;
    logic [4:0]  ob_wbrd;
    logic        ob_wbexc;
    logic [255:0] ob_stall;

    logic [105:0] all_out;
    assign all_out = {stall, ctrl_MULT, ctrl_DIV, wb_valid, wb_exception, wb_rd,
                      wb_data, data_operandA, data_operandB};

    always #5 clk = ~clk;

    multdiv_issue_ctrl dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .issue_valid    (issue_valid),
        .issue_is_div   (issue_is_div),
        .issue_opA      (issue_opA),
        .issue_opB      (issue_opB),
        .issue_rd       (issue_rd),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_exception   (wb_exception)
    );

    // What the arithmetic unit produces: {exception, result}
    function automatic logic [32:0] mdu(input bit is_div, input logic [31:0] a,
                                        input logic [31:0] b, input bit mexc);
        logic [31:0] r;
        if (is_div) begin
            if (b == 32'd0) return {1'b1, 32'd0};
            r = a / b;
            return {1'b0, r};
        end
        r = a * b;
        return {mexc, r};
    endfunction

    // Transaction-level expectation: issue at cycle 0, ready lat cycles after
    // the pulse (cycle 1), writeback at 2+lat unless flushed at/before then.
    function automatic void ref_model(input bit is_div, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] rd,
                                      input int lat, input bit mexc, input int flush_at,
                                      output int e_nwb, output int e_wbc,
                                      output logic [4:0] e_rd, output logic [31:0] e_data,
                                      output bit e_exc, output int e_stall_end);
        logic [32:0] md;
        md          = mdu(is_div, a, b, mexc);
        e_wbc       = 2 + lat;
        e_nwb       = 1;
        e_stall_end = e_wbc;
        if (flush_at >= 1 && flush_at <= e_wbc) begin
            e_nwb       = 0;
            e_stall_end = (flush_at < e_wbc) ? flush_at + 1 : e_wbc;
        end
        e_exc  = md[32];
        e_rd   = md[32] ? 5'd30 : rd;
        e_data = md[32] ? (is_div ? 32'd5 : 32'd4) : md[31:0];
    endfunction

    // Drive one operation for ncyc cycles, acting as the multdiv unit, and record what the DUT did.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit mexc,
                          input bit stale, input int flush_at, input int ncyc);
        logic [32:0] md;
        int pc;
        md = mdu(is_div, a, b, mexc);
        pc = -1;
        ob_nmult = 0; ob_ndiv = 0; ob_pulse_c = -1; ob_nwb = 0; ob_wbc = -1;
        ob_opa = '0; ob_opb = '0; ob_wbrd = '0; ob_wbdata = '0; ob_wbexc = 1'b0;
        ob_stall = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (ctrl_MULT || ctrl_DIV) begin
                if (ctrl_MULT) ob_nmult++;
                if (ctrl_DIV) ob_ndiv++;
                ob_pulse_c = c;
                pc = c;
                ob_opa = data_operandA;
                ob_opb = data_operandB;
            end
            issue_valid  = (c == 0);
            issue_is_div = (c == 0) ? is_div : 1'($urandom);
            issue_opA    = (c == 0) ? a : $urandom;
            issue_opB    = (c == 0) ? b : $urandom;
            issue_rd     = (c == 0) ? rd : 5'($urandom);
            flush        = (c == flush_at);
            if (lat >= 0 && pc >= 0 && c == pc + lat) begin
                data_resultRDY = 1'b1;
                data_result    = md[31:0];
                data_exception = md[32];
            end else begin
                data_resultRDY = stale && (c == 1);
                data_result    = $urandom;
                data_exception = 1'($urandom);
            end
            #1;
            ob_stall[c] = stall;
            if (wb_valid) begin
                ob_nwb++;
                ob_wbc    = c;
                ob_wbrd   = wb_rd;
                ob_wbdata = wb_data;
                ob_wbexc  = wb_exception;
            end
        end
        issue_valid    = 1'b0;
        flush          = 1'b0;
        data_resultRDY = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0; issue_opA = '0;
        issue_opB = '0; issue_rd = '0; flush = 1'b0; data_result = '0;
        data_exception = 1'b0; data_resultRDY = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (all_out !== 106'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (all_out !== 106'd0) begin
            failures++;
            $display("FAIL reset_release_idle got=%h want=0", all_out);
        end
    endtask

    task automatic test_mult();
        int nbad;
        run_op(1'b0, 32'd7, 32'd6, 5'd9, 33, 1'b0, 1'b0, -1, 40);
        $display("txn mult 7*6 wb_cycle=%0d rd=%0d data=%0d exc=%0b", ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc);
        checks++;
        if (ob_nmult !== 1 || ob_ndiv !== 0 || ob_pulse_c !== 1) begin
            failures++;
            $display("FAIL mult_pulse got mult=%0d div=%0d at=%0d want 1/0/1", ob_nmult, ob_ndiv, ob_pulse_c);
        end
        checks++;
        if (ob_opa !== 32'd7 || ob_opb !== 32'd6) begin
            failures++;
            $display("FAIL mult_operands got %0d,%0d want 7,6", ob_opa, ob_opb);
        end
        checks++;
        if (ob_nwb !== 1 || ob_wbc !== 35) begin
            failures++;
            $display("FAIL mult_wb_timing got n=%0d cyc=%0d want 1/35", ob_nwb, ob_wbc);
        end
        checks++;
        if (ob_wbrd !== 5'd9 || ob_wbdata !== 32'd42 || ob_wbexc !== 1'b0) begin
            failures++;
            $display("FAIL mult_payload got rd=%0d data=%0d exc=%0b want 9/42/0", ob_wbrd, ob_wbdata, ob_wbexc);
        end
        nbad = 0;
        for (int c = 0; c < 40; c++) if (ob_stall[c] !== (c < 35)) nbad++;
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL mult_stall got %0d bad cycles want 0", nbad);
        end
    endtask

    task automatic test_div_exc();
        run_op(1'b1, 32'd100, 32'd0, 5'd12, 10, 1'b0, 1'b0, -1, 16);
        $display("txn div 100/0 wb_cycle=%0d rd=%0d data=%0d exc=%0b", ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc);
        checks++;
        if (ob_ndiv !== 1 || ob_nmult !== 0) begin
            failures++;
            $display("FAIL div_pulse got div=%0d mult=%0d want 1/0", ob_ndiv, ob_nmult);
        end
        checks++;
        if (ob_nwb !== 1 || ob_wbrd !== 5'd30 || ob_wbdata !== 32'd5 || ob_wbexc !== 1'b1) begin
            failures++;
            $display("FAIL div_exc_payload got n=%0d rd=%0d data=%0d exc=%0b want 1/30/5/1",
                     ob_nwb, ob_wbrd, ob_wbdata, ob_wbexc);
        end
    endtask

    task automatic test_stale_ready();
        run_op(1'b0, 32'd1234, 32'd77, 5'd3, 5, 1'b0, 1'b1, -1, 12);
        $display("txn stale-ready mult wb_cycle=%0d data=%0d", ob_wbc, ob_wbdata);
        checks++;
        if (ob_nwb !== 1 || ob_wbc !== 7 || ob_wbdata !== 32'd95018) begin
            failures++;
            $display("FAIL stale_ready got n=%0d cyc=%0d data=%0d want 1/7/95018", ob_nwb, ob_wbc, ob_wbdata);
        end
    endtask

    task automatic test_flush();
        int nbad;
        // Flush on the 10th BUSY cycle
        run_op(1'b0, 32'd123, 32'd456, 5'd3, 33, 1'b0, 1'b0, 11, 13);
        $display("txn flush-busy wb_count=%0d", ob_nwb);
        nbad = 0;
        for (int c = 0; c < 13; c++) if (ob_stall[c] !== (c < 12)) nbad++;
        checks++;
        if (ob_nwb !== 0 || nbad !== 0) begin
            failures++;
            $display("FAIL flush_busy got wb=%0d stall_bad=%0d want 0/0", ob_nwb, nbad);
        end
        // Fresh issue two cycles after the flush
        run_op(1'b1, 32'd1000, 32'd7, 5'd4, 20, 1'b0, 1'b0, -1, 26);
        $display("txn div-after-flush wb_cycle=%0d data=%0d", ob_wbc, ob_wbdata);
        checks++;
        if (ob_ndiv !== 1 || ob_pulse_c !== 1 || ob_nwb !== 1 || ob_wbc !== 22 ||
            ob_wbdata !== 32'd142 || ob_wbrd !== 5'd4) begin
            failures++;
            $display("FAIL after_flush got div=%0d pc=%0d n=%0d cyc=%0d data=%0d rd=%0d want 1/1/1/22/142/4",
                     ob_ndiv, ob_pulse_c, ob_nwb, ob_wbc, ob_wbdata, ob_wbrd);
        end
        // Flush coinciding with ready in BUSY
        run_op(1'b0, 32'd3, 32'd5, 5'd6, 4, 1'b0, 1'b0, 5, 10);
        checks++;
        if (ob_nwb !== 0) begin
            failures++;
            $display("FAIL flush_with_ready got wb=%0d want 0", ob_nwb);
        end
        // Flush during DONE
        run_op(1'b0, 32'd3, 32'd5, 5'd6, 4, 1'b0, 1'b0, 6, 10);
        checks++;
        if (ob_nwb !== 0) begin
            failures++;
            $display("FAIL flush_in_done got wb=%0d want 0", ob_nwb);
        end
    endtask

    task automatic test_reset_mid_busy();
        int nwb, npulse, nstall;
        @(negedge clk);
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd5; issue_opB = 32'd9; issue_rd = 5'd2;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 106'd0) begin
            failures++;
            $display("FAIL reset_mid_busy got=%h want=0", all_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        nwb = 0; npulse = 0; nstall = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            data_resultRDY = 1'b1;
            data_result    = 32'd45;
            #1;
            if (wb_valid) nwb++;
            if (ctrl_MULT || ctrl_DIV) npulse++;
            if (stall) nstall++;
        end
        data_resultRDY = 1'b0;
        $display("txn reset-mid-busy wb=%0d pulses=%0d stalls=%0d", nwb, npulse, nstall);
        checks++;
        if (nwb !== 0 || npulse !== 0 || nstall !== 0) begin
            failures++;
            $display("FAIL after_reset got wb=%0d pulse=%0d stall=%0d want 0/0/0", nwb, npulse, nstall);
        end
    endtask

    task automatic test_timeout();
        int nbad;
`ifdef MD_TIMEOUT_EN
        run_op(1'b0, 32'd2, 32'd3, 5'd7, -1, 1'b0, 1'b0, -1, 72);
        $display("txn timeout wb_cycle=%0d rd=%0d data=%0d exc=%0b", ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc);
        checks++;
        if (ob_nwb !== 1 || ob_wbc !== 66 || ob_wbrd !== 5'd30 || ob_wbdata !== 32'd4 || ob_wbexc !== 1'b1) begin
            failures++;
            $display("FAIL timeout got n=%0d cyc=%0d rd=%0d data=%0d exc=%0b want 1/66/30/4/1",
                     ob_nwb, ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc);
        end
`else
        run_op(1'b0, 32'd2, 32'd3, 5'd7, -1, 1'b0, 1'b0, -1, 150);
        nbad = 0;
        for (int c = 0; c < 150; c++) if (ob_stall[c] !== 1'b1) nbad++;
        $display("txn no-ready wb=%0d stall_low_cycles=%0d", ob_nwb, nbad);
        checks++;
        if (ob_nwb !== 0 || nbad !== 0) begin
            failures++;
            $display("FAIL no_timeout got wb=%0d stall_low=%0d want 0/0", ob_nwb, nbad);
        end
`endif
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cleanup got stall=%0b want 0", stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] pv, wv, sv, epv, ewv, esv;
        int lastp, nbad;
        pv = '0; wv = '0; sv = '0; epv = '0; ewv = '0;
        lastp = -10; nbad = 0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (ctrl_MULT) begin pv[c] = 1'b1; lastp = c; end
            if (ctrl_DIV) nbad++;
            issue_valid = (c <= 8); issue_is_div = 1'b0;
            issue_opA = 32'd11; issue_opB = 32'd13; issue_rd = 5'd5; flush = 1'b0;
            data_resultRDY = (c == lastp + 1);
            data_result    = (c == lastp + 1) ? 32'd143 : $urandom;
            data_exception = 1'b0;
            #1;
            wv[c] = wb_valid;
            sv[c] = stall;
            if (wb_valid && (wb_data !== 32'd143 || wb_rd !== 5'd5)) nbad++;
        end
        issue_valid = 1'b0; data_resultRDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            epv[4*k+1] = 1'b1;
            ewv[4*k+3] = 1'b1;
        end
        esv = ~ewv;
        esv[12] = 1'b0;
        $display("txn back-to-back pulses=%b wb=%b", pv, wv);
        checks++;
        if (pv !== epv) begin
            failures++;
            $display("FAIL b2b_pulses got %b want %b", pv, epv);
        end
        checks++;
        if (wv !== ewv || nbad !== 0) begin
            failures++;
            $display("FAIL b2b_wb got %b bad=%0d want %b bad=0", wv, nbad, ewv);
        end
        checks++;
        if (sv !== esv) begin
            failures++;
            $display("FAIL b2b_stall got %b want %b", sv, esv);
        end
    endtask

    task automatic test_random();
        bit          is_div, mexc, stale, e_exc;
        logic [31:0] a, b, e_data;
        logic [4:0]  rd, e_rd;
        int          lat, flush_at, ncyc, e_nwb, e_wbc, e_stall_end, nbad;
        for (int t = 0; t < 25; t++) begin
            is_div   = 1'($urandom);
            a        = $urandom;
            b        = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            rd       = 5'($urandom);
            lat      = int'($urandom_range(1, 40));
            mexc     = ($urandom_range(0, 5) == 0);
            stale    = 1'($urandom);
            flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat + 3)) : -1;
            ncyc     = lat + 6;
            ref_model(is_div, a, b, rd, lat, mexc, flush_at, e_nwb, e_wbc, e_rd, e_data, e_exc, e_stall_end);
            run_op(is_div, a, b, rd, lat, mexc, stale, flush_at, ncyc);
            $display("txn rand %0d div=%0b a=%h b=%h lat=%0d flush=%0d wb=%0d@%0d rd=%0d data=%h exc=%0b",
                     t, is_div, a, b, lat, flush_at, ob_nwb, ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc);
            checks++;
            if (ob_pulse_c !== 1 || ob_nmult !== int'(!is_div) || ob_ndiv !== int'(is_div) ||
                ob_opa !== a || ob_opb !== b) begin
                failures++;
                $display("FAIL rand_issue t=%0d got pc=%0d m=%0d d=%0d a=%h b=%h want pc=1 div=%0b a=%h b=%h",
                         t, ob_pulse_c, ob_nmult, ob_ndiv, ob_opa, ob_opb, is_div, a, b);
            end
            checks++;
            if (ob_nwb !== e_nwb || (e_nwb == 1 && (ob_wbc !== e_wbc || ob_wbrd !== e_rd ||
                ob_wbdata !== e_data || ob_wbexc !== e_exc))) begin
                failures++;
                $display("FAIL rand_wb t=%0d got n=%0d cyc=%0d rd=%0d data=%h exc=%0b want n=%0d cyc=%0d rd=%0d data=%h exc=%0b",
                         t, ob_nwb, ob_wbc, ob_wbrd, ob_wbdata, ob_wbexc, e_nwb, e_wbc, e_rd, e_data, e_exc);
            end
            nbad = 0;
            for (int c = 0; c < ncyc; c++) if (ob_stall[c] !== (c < e_stall_end)) nbad++;
            checks++;
            if (nbad !== 0) begin
                failures++;
                $display("FAIL rand_stall t=%0d got %0d bad cycles want 0 (end=%0d)", t, nbad, e_stall_end);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div_exc();
        test_stale_ready();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
